// File: rtl/lock_attempt_ctrl.sv
// Gates button pulses into digital_lock, counts consecutive failed attempts,
// enforces a lockout after too many failures and aborts stale partial entries.
module lock_attempt_ctrl #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int ENTRY_TIMEOUT  = 100000000,
  parameter int CNT_W          = 27,
  localparam int FW            = $clog2(MAX_FAILS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    btn_in,
  input  logic          attempt_pass,
  input  logic          attempt_fail,
  output logic [3:0]    btn_out,
  output logic          entry_abort,
  output logic          locked_out,
  output logic [FW-1:0] fail_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TIMEOUT - 1);
  localparam logic [FW-1:0]    FAIL_MAX   = FW'(MAX_FAILS);

  state_t           state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic             one_hot;
  logic [FW-1:0]    fail_next;

  // Exactly one button: nonzero and clearing the lowest set bit leaves nothing.
  assign one_hot   = (btn_in != 4'd0) && ((btn_in & (btn_in - 4'd1)) == 4'd0);
  assign fail_next = (fail_count == FAIL_MAX) ? FAIL_MAX : fail_count + FW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      btn_out     <= 4'd0;
      entry_abort <= 1'b0;
      locked_out  <= 1'b0;
      fail_count  <= '0;
    end else begin
      btn_out     <= 4'd0;
      entry_abort <= 1'b0;
      case (state_reg)
        LOCKOUT: begin
          if (timer_reg == '0) begin
            state_reg  <= IDLE;
            locked_out <= 1'b0;
            fail_count <= '0;
          end else begin
            timer_reg <= timer_reg - CNT_W'(1);
          end
        end
        default: begin
          if (attempt_fail) begin
            fail_count <= fail_next;
            if (fail_next == FAIL_MAX) begin
              state_reg  <= LOCKOUT;
              timer_reg  <= LOCK_LOAD;
              locked_out <= 1'b1;
            end else begin
              state_reg <= IDLE;
              timer_reg <= '0;
              if (one_hot) btn_out <= btn_in;
            end
          end else if (attempt_pass) begin
            fail_count <= '0;
            state_reg  <= IDLE;
            timer_reg  <= '0;
            if (one_hot) btn_out <= btn_in;
          end else if (one_hot) begin
            btn_out   <= btn_in;
            state_reg <= ENTRY;
            timer_reg <= ENTRY_LOAD;
          end else if (state_reg == ENTRY) begin
            if (timer_reg == '0) begin
              entry_abort <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              timer_reg <= timer_reg - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl: directed scenarios plus a random
// run, all compared against a cycle-count reference model.
module tb_lock_attempt_ctrl;

  localparam int MAXF = 3;
  localparam int LOCK = 20;
  localparam int TOUT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'd0;
  logic       attempt_pass = 1'b0;
  logic       attempt_fail = 1'b0;
  logic [3:0] btn_out;
  logic       entry_abort;
  logic       locked_out;
  logic [1:0] fail_count;

  int tests = 0;
  int fails = 0;

  // Reference model: counts of cycles remaining / elapsed, not an FSM.
  int         m_fail = 0;
  int         m_lock_left = 0;
  bit         m_in_entry = 0;
  int         m_idle = 0;
  logic [3:0] m_btn = 4'd0;
  bit         m_abort = 0;

  lock_attempt_ctrl #(
    .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK), .ENTRY_TIMEOUT(TOUT), .CNT_W(27)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .attempt_pass(attempt_pass),
    .attempt_fail(attempt_fail), .btn_out(btn_out), .entry_abort(entry_abort),
    .locked_out(locked_out), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic r, input logic [3:0] b, input logic p, input logic f);
    m_btn   = 4'd0;
    m_abort = 0;
    if (!r) begin
      m_fail = 0; m_lock_left = 0; m_in_entry = 0; m_idle = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (f) begin
      m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
      m_in_entry = 0;
      if (m_fail == MAXF) m_lock_left = LOCK;
      else if ($countones(b) == 1) m_btn = b;
    end else if (p) begin
      m_fail = 0;
      m_in_entry = 0;
      if ($countones(b) == 1) m_btn = b;
    end else if ($countones(b) == 1) begin
      m_btn = b; m_in_entry = 1; m_idle = 0;
    end else if (m_in_entry) begin
      m_idle++;
      if (m_idle == TOUT) begin
        m_abort = 1; m_in_entry = 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic [3:0] b, input logic p, input logic f);
    rst_n = r; btn_in = b; attempt_pass = p; attempt_fail = f;
    @(posedge clk);
    model_step(r, b, p, f);
    #1;
    rst_n = 1'b1; btn_in = 4'd0; attempt_pass = 1'b0; attempt_fail = 1'b0;
  endtask

  task automatic test_reset;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'd0) begin fails++; $display("FAIL reset_btn_out: got %b, required 0000", btn_out); end
    tests++; if (entry_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b, required 0", entry_abort); end
    tests++; if (locked_out !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b, required 0", locked_out); end
    tests++; if (fail_count !== 2'd0) begin fails++; $display("FAIL reset_fail_count: got %0d, required 0", fail_count); end
    tick(1'b1, 4'b0100, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'b0100) begin fails++; $display("FAIL press_forward: got %b, required 0100", btn_out); end
    tick(1'b1, 4'b0000, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'b0000) begin fails++; $display("FAIL press_one_cycle: got %b, required 0000", btn_out); end
    tick(1'b1, 4'b0011, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'b0000) begin fails++; $display("FAIL multibit_dropped: got %b, required 0000", btn_out); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_timeout;
    int abort_at;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'b1000, 1'b0, 1'b0);
    abort_at = -1;
    for (int i = 1; i <= TOUT + 3; i++) begin
      tick(1'b1, 4'd0, 1'b0, 1'b0);
      tests++;
      if (entry_abort !== m_abort) begin
        fails++; $display("FAIL timeout_abort cycle %0d: got %b, required %b", i, entry_abort, m_abort);
      end
      if (entry_abort === 1'b1) abort_at = (abort_at < 0) ? i : -2;
    end
    tests++; if (abort_at != TOUT) begin fails++; $display("FAIL timeout_distance: got %0d, required %0d", abort_at, TOUT); end
    tests++; if (fail_count !== 2'd1) begin fails++; $display("FAIL timeout_fail_count: got %0d, required 1", fail_count); end
    $display("[TB] test_timeout done, abort after %0d cycles", abort_at);
  endtask

  task automatic test_fail_pass;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'd0, 1'b0, 1'b1);
    tests++; if (fail_count !== 2'd2) begin fails++; $display("FAIL two_fails: got %0d, required 2", fail_count); end
    tick(1'b1, 4'd0, 1'b1, 1'b0);
    tests++; if (fail_count !== 2'd0) begin fails++; $display("FAIL pass_clears: got %0d, required 0", fail_count); end
    tests++; if (locked_out !== 1'b0) begin fails++; $display("FAIL pass_no_lock: got %b, required 0", locked_out); end
    $display("[TB] test_fail_pass done");
  endtask

  task automatic test_lockout;
    int high;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < MAXF; i++) tick(1'b1, 4'd0, 1'b0, 1'b1);
    high = (locked_out === 1'b1) ? 1 : 0;
    for (int i = 0; i < LOCK + 4; i++) begin
      tick(1'b1, 4'(1 << $urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (locked_out === 1'b1) high++;
      tests++;
      if (btn_out !== m_btn || locked_out !== (m_lock_left > 0)) begin
        fails++; $display("FAIL lockout_cycle %0d: got btn %b lock %b, required btn %b lock %b",
                          i, btn_out, locked_out, m_btn, m_lock_left > 0);
      end
      if (locked_out !== 1'b1) break;
    end
    tests++; if (high != LOCK) begin fails++; $display("FAIL lockout_length: got %0d, required %0d", high, LOCK); end
    tests++; if (fail_count !== 2'd0) begin fails++; $display("FAIL lockout_clears: got %0d, required 0", fail_count); end
    tick(1'b1, 4'b0010, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'b0010) begin fails++; $display("FAIL post_lock_press: got %b, required 0010", btn_out); end
    $display("[TB] test_lockout done, locked %0d cycles", high);
  endtask

  task automatic test_simultaneous;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b1, 1'b1);
    tests++; if (fail_count !== 2'd1) begin fails++; $display("FAIL pass_fail_same: got %0d, required 1", fail_count); end
    tick(1'b1, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'b0001, 1'b0, 1'b1);
    tests++; if (btn_out !== 4'b0000) begin fails++; $display("FAIL lock_press_dropped: got %b, required 0000", btn_out); end
    tests++; if (locked_out !== 1'b1) begin fails++; $display("FAIL lock_entered: got %b, required 1", locked_out); end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_reset_mid_lockout;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < MAXF; i++) tick(1'b1, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b1, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tests++; if (locked_out !== 1'b0) begin fails++; $display("FAIL rst_mid_lock: got %b, required 0", locked_out); end
    tests++; if (fail_count !== 2'd0) begin fails++; $display("FAIL rst_mid_count: got %0d, required 0", fail_count); end
    tick(1'b1, 4'b1000, 1'b0, 1'b0);
    tests++; if (btn_out !== 4'b1000) begin fails++; $display("FAIL rst_then_press: got %b, required 1000", btn_out); end
    $display("[TB] test_reset_mid_lockout done");
  endtask

  task automatic test_random;
    int bad;
    logic [3:0] b;
    logic r, p, f;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 199) != 0);
      case ($urandom_range(0, 9))
        0, 1:    b = 4'(1 << $urandom_range(0, 3));
        2:       b = 4'($urandom_range(0, 15));
        default: b = 4'd0;
      endcase
      p = ($urandom_range(0, 24) == 0);
      f = ($urandom_range(0, 11) == 0);
      tick(r, b, p, f);
      tests++;
      if (btn_out !== m_btn || entry_abort !== m_abort || locked_out !== (m_lock_left > 0) ||
          fail_count !== 2'(m_fail)) begin
        fails++; bad++;
        $display("FAIL random cycle %0d: got btn %b abort %b lock %b cnt %0d, required btn %b abort %b lock %b cnt %0d",
                 i, btn_out, entry_abort, locked_out, fail_count, m_btn, m_abort, m_lock_left > 0, m_fail);
      end
    end
    $display("[TB] test_random done, %0d mismatching cycles", bad);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_fail_pass();
    test_lockout();
    test_simultaneous();
    test_reset_mid_lockout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
